// File: rtl/valid_ready_width_upsizer.sv
// -----------------------------------------------------------------------------
// valid_ready_width_upsizer
//
// Packs consecutive narrow valid/ready beats into one wide word, lane 0 first,
// and offers each word through a registered valid/ready output stage. A beat
// flagged with input_last closes the current word early, so packet tails are
// never left waiting in the accumulator. The output side is meant to feed the
// write port of an asynchronous FIFO directly, so each clock-domain crossing
// carries RATIO beats instead of one.
//
// Ports:
//   clock         in   1             single clock, rising edge
//   reset         in   1             synchronous, active-high
//   input_data    in   INPUT_WIDTH   narrow beat
//   input_last    in   1             beat closes the current word
//   input_valid   in   1             beat offered
//   input_ready   out  1             beat can be accepted (combinational)
//   output_data   out  OUTPUT_WIDTH  packed word, unfilled lanes are zero
//   output_count  out  COUNT_WIDTH   filled lanes, 1..RATIO
//   output_last   out  1             word was closed by input_last
//   output_valid  out  1             word offered
//   output_ready  in   1             downstream accepts word
// -----------------------------------------------------------------------------
module valid_ready_width_upsizer #(
    parameter int INPUT_WIDTH = 8,
    parameter int RATIO       = 4
) (
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic [INPUT_WIDTH-1:0]                 input_data,
    input  logic                                   input_last,
    input  logic                                   input_valid,
    output logic                                   input_ready,
    output logic [INPUT_WIDTH*RATIO-1:0]           output_data,
    output logic [$clog2(RATIO+1)-1:0]             output_count,
    output logic                                   output_last,
    output logic                                   output_valid,
    input  logic                                   output_ready
);

    localparam int OUTPUT_WIDTH = INPUT_WIDTH * RATIO;
    localparam int COUNT_WIDTH  = $clog2(RATIO + 1);

    localparam logic [COUNT_WIDTH-1:0] LAST_LANE = COUNT_WIDTH'(RATIO - 1);

    // Accumulator: lanes filled so far for the word being built.
    logic [OUTPUT_WIDTH-1:0] acc_data_q,     acc_data_d;
    logic [COUNT_WIDTH-1:0]  acc_count_q,    acc_count_d;

    // Output register stage.
    logic [OUTPUT_WIDTH-1:0] output_data_q,  output_data_d;
    logic [COUNT_WIDTH-1:0]  output_count_q, output_count_d;
    logic                    output_last_q,  output_last_d;
    logic                    output_valid_q, output_valid_d;

    logic                    accept;
    logic                    completing;
    logic                    drain;
    logic [OUTPUT_WIDTH-1:0] merged_data;

    // The output stage can take a new word when it is empty or being drained
    // on this edge; that combinational path from output_ready is what lets a
    // full stream run at one beat per cycle.
    assign input_ready = !reset && (!output_valid_q || output_ready);

    assign accept     = input_valid && input_ready;
    assign completing = accept && ((acc_count_q == LAST_LANE) || input_last);
    assign drain      = output_valid_q && output_ready;

    // Accumulated lanes below acc_count, the new beat in lane acc_count, and
    // zeros above it. Lanes above acc_count are already zero in acc_data_q,
    // but forcing them here keeps the emitted word clean by construction.
    always_comb begin
        // NOTE: every signal written in a combinational block gets a default
        // first, otherwise a path that skips the assignment infers a latch.
        merged_data = '0;
        for (int lane = 0; lane < RATIO; lane++) begin
            if (COUNT_WIDTH'(lane) < acc_count_q) begin
                merged_data[lane*INPUT_WIDTH +: INPUT_WIDTH] =
                    acc_data_q[lane*INPUT_WIDTH +: INPUT_WIDTH];
            end else if (COUNT_WIDTH'(lane) == acc_count_q) begin
                merged_data[lane*INPUT_WIDTH +: INPUT_WIDTH] = input_data;
            end
        end
    end

    always_comb begin
        acc_data_d     = acc_data_q;
        acc_count_d    = acc_count_q;
        output_data_d  = output_data_q;
        output_count_d = output_count_q;
        output_last_d  = output_last_q;
        output_valid_d = output_valid_q;

        // A drain only empties the stage; data, count and last keep their
        // stale values so nothing toggles needlessly downstream.
        if (drain) begin
            output_valid_d = 1'b0;
        end

        if (accept) begin
            if (completing) begin
                // A load on the same edge as a drain overrides the clear above,
                // so the new word replaces the old one and valid stays high.
                output_data_d  = merged_data;
                output_count_d = acc_count_q + COUNT_WIDTH'(1);
                output_last_d  = input_last;
                output_valid_d = 1'b1;
                acc_data_d     = '0;
                acc_count_d    = '0;
            end else begin
                acc_data_d  = merged_data;
                acc_count_d = acc_count_q + COUNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        // NOTE: the accumulator and the output word are plain flops rather
        // than a memory, so they are cleared on reset like any other state;
        // this is what discards a half-built word and any pending output.
        if (reset) begin
            acc_data_q     <= '0;
            acc_count_q    <= '0;
            output_data_q  <= '0;
            output_count_q <= '0;
            output_last_q  <= 1'b0;
            output_valid_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value of every other flop.
            acc_data_q     <= acc_data_d;
            acc_count_q    <= acc_count_d;
            output_data_q  <= output_data_d;
            output_count_q <= output_count_d;
            output_last_q  <= output_last_d;
            output_valid_q <= output_valid_d;
        end
    end

    assign output_data  = output_data_q;
    assign output_count = output_count_q;
    assign output_last  = output_last_q;
    assign output_valid = output_valid_q;

endmodule

// File: tb/tb_valid_ready_width_upsizer.sv
// -----------------------------------------------------------------------------
// Testbench for valid_ready_width_upsizer (INPUT_WIDTH=8, RATIO=4).
// Inputs change 1 ns after the rising edge; outputs are sampled on the falling
// edge. A reference model turns every accepted beat into an expected word and
// queues it; an independent monitor pops and compares each transferred word.
// -----------------------------------------------------------------------------
module tb_valid_ready_width_upsizer;

    localparam int IW = 8;
    localparam int RATIO = 4;
    localparam int OW = IW * RATIO;
    localparam int CW = $clog2(RATIO + 1);

    typedef struct {
        logic [OW-1:0] data;
        int            count;
        logic          last;
    } word_t;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [IW-1:0] input_data = '0;
    logic          input_last = 1'b0;
    logic          input_valid = 1'b0;
    logic          input_ready;
    logic [OW-1:0] output_data;
    logic [CW-1:0] output_count;
    logic          output_last;
    logic          output_valid;
    logic          output_ready = 1'b1;

    int n_checks = 0;
    int n_fail   = 0;
    int words_seen = 0;

    word_t         exp_q[$];
    logic [IW-1:0] model_lanes[$];

    valid_ready_width_upsizer #(.INPUT_WIDTH(IW), .RATIO(RATIO)) dut (
        .clock        (clock),
        .reset        (reset),
        .input_data   (input_data),
        .input_last   (input_last),
        .input_valid  (input_valid),
        .input_ready  (input_ready),
        .output_data  (output_data),
        .output_count (output_count),
        .output_last  (output_last),
        .output_valid (output_valid),
        .output_ready (output_ready)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: collect accepted beats; a word closes after RATIO
    // beats or on a last beat. Values at the falling edge are the values the
    // DUT sees at the next rising edge.
    always @(negedge clock) begin
        if (reset) begin
            model_lanes.delete();
            exp_q.delete();
        end else if (input_valid && input_ready) begin
            model_lanes.push_back(input_data);
            if (model_lanes.size() == RATIO || input_last) begin
                word_t w;
                w.data  = '0;
                for (int i = 0; i < model_lanes.size(); i++)
                    w.data = w.data | (OW'(model_lanes[i]) << (IW * i));
                w.count = model_lanes.size();
                w.last  = input_last;
                exp_q.push_back(w);
                model_lanes.delete();
            end
        end
    end

    // Monitor: every word handed downstream must match the oldest expected.
    always @(negedge clock) begin
        if (!reset && output_valid && output_ready) begin
            words_seen++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_word: got 0x%0h, expected no word at %0t", output_data, $time);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                check("word_data",  output_data,  w.data);
                check("word_count", output_count, w.count);
                check("word_last",  output_last,  w.last);
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Offer one beat and hold it until accepted (bounded).
    task automatic send_beat(input logic [IW-1:0] d, input logic l);
        bit done = 0;
        input_data  = d;
        input_last  = l;
        input_valid = 1'b1;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clock);
            if (input_ready) done = 1;
            step();
        end
        input_valid = 1'b0;
        input_last  = 1'b0;
        if (!done) check("send_beat_timeout", 1, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int accepted;
        int cycles;
        int words_before;

        // Reset state.
        step();
        step();
        @(negedge clock);
        check("reset_input_ready", input_ready, 0);
        check("reset_output_valid", output_valid, 0);
        check("reset_output_data", output_data, 0);
        check("reset_output_count", output_count, 0);
        check("reset_output_last", output_last, 0);
        step();
        reset = 1'b0;
        @(negedge clock);
        check("post_reset_input_ready", input_ready, 1);
        step();

        // Full word, visible right after the completing edge for one cycle.
        send_beat(8'h11, 0);
        send_beat(8'h22, 0);
        send_beat(8'h33, 0);
        send_beat(8'h44, 0);
        check("full_valid", output_valid, 1);
        check("full_data", output_data, 32'h44332211);
        check("full_count", output_count, 4);
        check("full_last", output_last, 0);
        step();
        check("full_valid_one_cycle", output_valid, 0);

        // Early close with input_last.
        send_beat(8'hAA, 0);
        send_beat(8'hBB, 1);
        check("early_data", output_data, 32'h0000BBAA);
        check("early_count", output_count, 2);
        check("early_last", output_last, 1);
        step();

        // Last on the very first beat.
        send_beat(8'h5A, 1);
        check("first_last_data", output_data, 32'h0000005A);
        check("first_last_count", output_count, 1);
        step();

        // Backpressure: pending word holds stable, input_ready low.
        output_ready = 1'b0;
        send_beat(8'h55, 0);
        send_beat(8'h66, 0);
        send_beat(8'h77, 0);
        send_beat(8'h88, 0);
        words_before = words_seen;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            check("bp_input_ready", input_ready, 0);
            check("bp_valid", output_valid, 1);
            check("bp_data", output_data, 32'h88776655);
            check("bp_count", output_count, 4);
            step();
        end
        output_ready = 1'b1;
        #1;
        check("bp_ready_returns", input_ready, 1);
        step();
        check("bp_drained", output_valid, 0);
        check("bp_single_transfer", words_seen - words_before, 1);

        // Throughput: 40 back-to-back beats.
        words_before = words_seen;
        for (int i = 0; i < 40; i++) begin
            input_data  = IW'(i + 1);
            input_last  = 1'b0;
            input_valid = 1'b1;
            @(negedge clock);
            check("tp_input_ready", input_ready, 1);
            step();
        end
        input_valid = 1'b0;
        check("tp_last_word_valid", output_valid, 1);
        check("tp_last_word_data", output_data, 32'h28272625);
        step();
        check("tp_word_count", words_seen - words_before, 10);

        // Reset mid-word discards the partial word.
        send_beat(8'h01, 0);
        send_beat(8'h02, 0);
        reset = 1'b1;
        @(negedge clock);
        check("rst_input_ready", input_ready, 0);
        step();
        reset = 1'b0;
        check("rst_output_valid", output_valid, 0);
        send_beat(8'h10, 0);
        send_beat(8'h20, 0);
        send_beat(8'h30, 0);
        send_beat(8'h40, 0);
        check("rst_word_data", output_data, 32'h40302010);
        check("rst_word_count", output_count, 4);
        step();

        // Random valid / last / ready.
        accepted = 0;
        cycles = 0;
        while (accepted < 500 && cycles < 20000) begin
            input_data   = IW'($urandom);
            input_valid  = $urandom_range(0, 1) == 1;
            input_last   = $urandom_range(0, 1) == 1;
            output_ready = $urandom_range(0, 1) == 1;
            @(negedge clock);
            if (input_valid && input_ready) accepted++;
            step();
            cycles++;
        end
        check("rand_beats_accepted", accepted, 500);
        input_valid  = 1'b0;
        input_last   = 1'b0;
        output_ready = 1'b1;
        send_beat(8'hFF, 1);
        for (int i = 0; i < 4; i++) step();
        check("rand_no_loss", exp_q.size(), 0);
        check("rand_drained", output_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
